wb_stage: RTL and testbench

- Write-back stage of the pipeline; sits directly upstream of the 32-entry register file.
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- Waits for load data when needed, and sign- or zero-extends it per funct3.
- Drives the register file's write port (wb_flag, rd, data) and keeps a retired-instruction counter.

---
 rtl/cpu_defs.sv | 26 ++
 rtl/load_ext.sv | 25 ++
 rtl/wb_stage.sv | 113 +++++++++++
 tb/tb_wb_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared pipeline definitions: default datapath width, write-back FSM
// states, load funct3 codes and the pending-load record.
package cpu_defs;

  localparam int unsigned DEFAULT_LEN = 32;
  localparam int unsigned RF_IDX_W    = 5;
  localparam int unsigned F3_W        = 3;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Destination and width code of a load waiting for its data.
  typedef struct packed {
    logic [RF_IDX_W-1:0] rd;
    logic [F3_W-1:0]     funct3;
  } pend_load_t;

endpackage

// File: rtl/load_ext.sv
// Load data extender: sign/zero-extends right-aligned load data by funct3.
// Ports: funct3 (load width/sign code), raw (right-aligned data),
//        ext_data_c (extended data, combinational).
module load_ext #(
  parameter int unsigned LEN = cpu_defs::DEFAULT_LEN
) (
  input  logic [2:0]     funct3,
  input  logic [LEN-1:0] raw,
  output logic [LEN-1:0] ext_data_c
);
  import cpu_defs::*;

  always_comb begin
    ext_data_c = raw;
    case (funct3)
      F3_LB:   ext_data_c = {{(LEN-8){raw[7]}}, raw[7:0]};
      F3_LH:   ext_data_c = {{(LEN-16){raw[15]}}, raw[15:0]};
      F3_LW:   ext_data_c = raw;
      F3_LBU:  ext_data_c = {{(LEN-8){1'b0}}, raw[7:0]};
      F3_LHU:  ext_data_c = {{(LEN-16){1'b0}}, raw[15:0]};
      default: ext_data_c = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts retiring instructions, waits for load data,
// drives the register-file write port and counts retired instructions.
// Ports: clk, rst (async, active-low), rdy_in (global enable);
//        in_* instruction handshake from the memory stage, in_ready back;
//        mem_done/mem_rdata load return;
//        wb_flag/wb_rd/wb_data register-file write port (registered);
//        retire_cnt retired-instruction counter; busy = waiting on a load.
module wb_stage #(
  parameter int unsigned LEN     = cpu_defs::DEFAULT_LEN,
  parameter int unsigned CNT_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_rd,
  input  logic [LEN-1:0]     in_result,
  input  logic               in_is_load,
  input  logic               in_no_wb,
  input  logic [2:0]         in_funct3,
  input  logic               mem_done,
  input  logic [LEN-1:0]     mem_rdata,
  output logic               wb_flag,
  output logic [4:0]         wb_rd,
  output logic [LEN-1:0]     wb_data,
  output logic [CNT_LEN-1:0] retire_cnt,
  output logic               busy
);
  import cpu_defs::*;

  wb_state_e          state_q, state_d;
  pend_load_t         pend_q, pend_d;
  logic               wb_flag_q, wb_flag_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [LEN-1:0]     wb_data_q, wb_data_d;
  logic [CNT_LEN-1:0] retire_cnt_q, retire_cnt_d;
  logic [LEN-1:0]     load_data_c;

  load_ext #(.LEN(LEN)) u_load_ext (
    .funct3     (pend_q.funct3),
    .raw        (mem_rdata),
    .ext_data_c (load_data_c)
  );

  assign in_ready   = rst && rdy_in && (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign wb_flag    = wb_flag_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign retire_cnt = retire_cnt_q;

  // Next-state and write-port logic; everything holds while rdy_in is low.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    wb_flag_d    = wb_flag_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    retire_cnt_d = retire_cnt_q;
    if (rdy_in) begin
      // wb_flag is a one-cycle pulse per writing instruction.
      wb_flag_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_no_wb) begin
              retire_cnt_d = retire_cnt_q + CNT_LEN'(1);
            end else if (!in_is_load) begin
              wb_flag_d    = (in_rd != 5'd0);
              wb_rd_d      = in_rd;
              wb_data_d    = in_result;
              retire_cnt_d = retire_cnt_q + CNT_LEN'(1);
            end else begin
              pend_d.rd     = in_rd;
              pend_d.funct3 = in_funct3;
              state_d       = WAIT_LOAD;
            end
          end
        end
        WAIT_LOAD: begin
          if (mem_done) begin
            wb_flag_d    = (pend_q.rd != 5'd0);
            wb_rd_d      = pend_q.rd;
            wb_data_d    = load_data_c;
            retire_cnt_d = retire_cnt_q + CNT_LEN'(1);
            state_d      = IDLE;
          end
        end
      endcase
    end
  end

  // State and output registers; reset discards any pending load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      wb_flag_q    <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      wb_flag_q    <= wb_flag_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic        in_no_wb;
  logic [2:0]  in_funct3;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        wb_flag;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [63:0] retire_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_cnt;

  wb_stage #(.LEN(32), .CNT_LEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy_in     (rdy_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_result  (in_result),
    .in_is_load (in_is_load),
    .in_no_wb   (in_no_wb),
    .in_funct3  (in_funct3),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .wb_flag    (wb_flag),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .retire_cnt (retire_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference load extension computed with plain arithmetic on the value.
  function automatic logic [31:0] ext_ref(input logic [2:0] f3, input logic [31:0] raw);
    longint v;
    case (f3)
      3'd0: begin v = longint'(raw % 256);   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = longint'(raw % 65536); if (v >= 32768) v = v - 65536; end
      3'd4: v = longint'(raw % 256);
      3'd5: v = longint'(raw % 65536);
      default: v = longint'(raw);
    endcase
    return v[31:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_rd = 5'd0; in_result = 32'd0; in_is_load = 1'b0;
    in_no_wb = 1'b0; in_funct3 = 3'd0; mem_done = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rdy_in = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%0h exp=0", wb_flag); end
    total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0h exp=0", wb_rd); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", wb_data); end
    total++; if (retire_cnt !== 64'd0) begin bad++; $display("FAIL reset_cnt got=%0h exp=0", retire_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", in_ready); end
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0h exp=1", in_ready); end
    exp_cnt = 64'd0;
  endtask

  task automatic test_alu();
    in_valid = 1'b1; in_rd = 5'd5; in_result = 32'h0000_1234;
    cyc();
    idle_inputs();
    exp_cnt++;
    total++; if (wb_flag !== 1'b1) begin bad++; $display("FAIL alu_flag got=%0h exp=1", wb_flag); end
    total++; if (wb_rd !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0h exp=5", wb_rd); end
    total++; if (wb_data !== 32'h1234) begin bad++; $display("FAIL alu_data got=%0h exp=1234", wb_data); end
    total++; if (retire_cnt !== exp_cnt) begin bad++; $display("FAIL alu_cnt got=%0h exp=%0h", retire_cnt, exp_cnt); end
    cyc();
    total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL alu_flag_drop got=%0h exp=0", wb_flag); end
    total++; if (wb_data !== 32'h1234) begin bad++; $display("FAIL alu_data_hold got=%0h exp=1234", wb_data); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s[3]  = '{3'd0, 3'd4, 3'd1};
    logic [31:0] raws[3] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001};
    logic [31:0] exps[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
    for (int k = 0; k < 3; k++) begin
      // mem_done is high (with junk) in the accept cycle and must be ignored.
      in_valid = 1'b1; in_rd = 5'd7; in_is_load = 1'b1; in_funct3 = f3s[k];
      mem_done = 1'b1; mem_rdata = 32'h5555_5555;
      cyc();
      idle_inputs();
      for (int w = 0; w < 2; w++) begin
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL load%0d_busy got=%0h exp=1", k, busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load%0d_ready got=%0h exp=0", k, in_ready); end
        total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL load%0d_wait_flag got=%0h exp=0", k, wb_flag); end
        cyc();
      end
      mem_done = 1'b1; mem_rdata = raws[k];
      cyc();
      idle_inputs();
      exp_cnt++;
      total++; if (wb_flag !== 1'b1) begin bad++; $display("FAIL load%0d_flag got=%0h exp=1", k, wb_flag); end
      total++; if (wb_rd !== 5'd7) begin bad++; $display("FAIL load%0d_rd got=%0h exp=7", k, wb_rd); end
      total++; if (wb_data !== exps[k]) begin bad++; $display("FAIL load%0d_data got=%0h exp=%0h", k, wb_data, exps[k]); end
      total++; if (retire_cnt !== exp_cnt) begin bad++; $display("FAIL load%0d_cnt got=%0h exp=%0h", k, retire_cnt, exp_cnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL load%0d_done_busy got=%0h exp=0", k, busy); end
      cyc();
    end
  endtask

  task automatic test_x0_nowb();
    in_valid = 1'b1; in_rd = 5'd0; in_result = 32'hCAFE_0000;
    cyc();
    exp_cnt++;
    total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL x0_flag got=%0h exp=0", wb_flag); end
    total++; if (retire_cnt !== exp_cnt) begin bad++; $display("FAIL x0_cnt got=%0h exp=%0h", retire_cnt, exp_cnt); end
    in_rd = 5'd9; in_no_wb = 1'b1; in_is_load = 1'b1; mem_done = 1'b1;
    cyc();
    idle_inputs();
    exp_cnt++;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nowb_busy got=%0h exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nowb_ready got=%0h exp=1", in_ready); end
    total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL nowb_flag got=%0h exp=0", wb_flag); end
    total++; if (retire_cnt !== exp_cnt) begin bad++; $display("FAIL nowb_cnt got=%0h exp=%0h", retire_cnt, exp_cnt); end
  endtask

  task automatic test_freeze();
    in_valid = 1'b1; in_rd = 5'd3; in_result = 32'hAA;
    cyc();
    exp_cnt++;
    in_valid = 1'b0; rdy_in = 1'b0;
    cyc();
    cyc();
    total++; if (wb_flag !== 1'b1) begin bad++; $display("FAIL frz_flag got=%0h exp=1", wb_flag); end
    total++; if (wb_rd !== 5'd3) begin bad++; $display("FAIL frz_rd got=%0h exp=3", wb_rd); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL frz_ready got=%0h exp=0", in_ready); end
    rdy_in = 1'b1;
    cyc();
    total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL frz_flag_drop got=%0h exp=0", wb_flag); end
    in_valid = 1'b1; in_rd = 5'd8; in_is_load = 1'b1; in_funct3 = 3'd2;
    cyc();
    idle_inputs();
    mem_done = 1'b1; mem_rdata = 32'hDEAD_BEEF; rdy_in = 1'b0;
    cyc();
    cyc();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL frz_ld_busy got=%0h exp=1", busy); end
    total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL frz_ld_flag got=%0h exp=0", wb_flag); end
    total++; if (retire_cnt !== exp_cnt) begin bad++; $display("FAIL frz_ld_cnt got=%0h exp=%0h", retire_cnt, exp_cnt); end
    rdy_in = 1'b1;
    cyc();
    mem_done = 1'b0;
    exp_cnt++;
    total++; if (wb_flag !== 1'b1) begin bad++; $display("FAIL frz_ld_done got=%0h exp=1", wb_flag); end
    total++; if (wb_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL frz_ld_data got=%0h exp=deadbeef", wb_data); end
    cyc();
    total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL frz_ld_once got=%0h exp=0", wb_flag); end
    total++; if (retire_cnt !== exp_cnt) begin bad++; $display("FAIL frz_ld_cnt2 got=%0h exp=%0h", retire_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1'b1; in_rd = 5'd6; in_result = 32'h55;
    cyc();
    in_rd = 5'd9; in_is_load = 1'b1; in_funct3 = 3'd2;
    cyc();
    idle_inputs();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rml_busy got=%0h exp=1", busy); end
    #2 rst = 1'b0;
    #1;
    total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL rml_rd got=%0h exp=0", wb_rd); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rml_data got=%0h exp=0", wb_data); end
    total++; if (retire_cnt !== 64'd0) begin bad++; $display("FAIL rml_cnt got=%0h exp=0", retire_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rml_busy0 got=%0h exp=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rml_ready got=%0h exp=0", in_ready); end
    cyc();
    rst = 1'b1;
    mem_done = 1'b1; mem_rdata = 32'h123;
    cyc();
    mem_done = 1'b0;
    exp_cnt = 64'd0;
    total++; if (wb_flag !== 1'b0) begin bad++; $display("FAIL rml_late_flag got=%0h exp=0", wb_flag); end
    total++; if (retire_cnt !== 64'd0) begin bad++; $display("FAIL rml_late_cnt got=%0h exp=0", retire_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_result = 32'(i * 32'h111);
      cyc();
      exp_cnt++;
      total++; if (wb_flag !== 1'b1) begin bad++; $display("FAIL b2b%0d_flag got=%0h exp=1", i, wb_flag); end
      total++; if (wb_rd !== 5'(i)) begin bad++; $display("FAIL b2b%0d_rd got=%0h exp=%0h", i, wb_rd, i); end
      total++; if (wb_data !== 32'(i * 32'h111)) begin bad++; $display("FAIL b2b%0d_data got=%0h exp=%0h", i, wb_data, i * 32'h111); end
    end
    idle_inputs();
    total++; if (retire_cnt !== 64'd4) begin bad++; $display("FAIL b2b_cnt got=%0h exp=4", retire_cnt); end
    force dut.retire_cnt_q = {64{1'b1}};
    #1 release dut.retire_cnt_q;
    in_valid = 1'b1; in_rd = 5'd10; in_result = 32'h77;
    cyc();
    idle_inputs();
    total++; if (retire_cnt !== 64'd0) begin bad++; $display("FAIL wrap_cnt got=%0h exp=0", retire_cnt); end
    cyc();
  endtask

  task automatic test_random();
    bit          waiting = 1'b0;
    logic [4:0]  p_rd = 5'd0;
    logic [2:0]  p_f3 = 3'd0;
    logic        m_flag = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic [63:0] m_cnt = 64'd0;
    rst = 1'b0;
    #1;
    cyc();
    rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rdy_in     = ($urandom % 8) != 0;
      in_valid   = $urandom % 2;
      in_rd      = 5'($urandom % 32);
      in_result  = $urandom;
      in_is_load = $urandom % 2;
      in_no_wb   = ($urandom % 5) == 0;
      in_funct3  = 3'($urandom % 8);
      mem_done   = ($urandom % 3) == 0;
      mem_rdata  = $urandom;
      #1;
      total++; if (in_ready !== (rdy_in && !waiting)) begin bad++; $display("FAIL rnd%0d_ready got=%0h exp=%0h", n, in_ready, rdy_in && !waiting); end
      if (rdy_in) begin
        m_flag = 1'b0;
        if (!waiting) begin
          if (in_valid) begin
            if (in_no_wb) m_cnt++;
            else if (!in_is_load) begin
              m_cnt++; m_rd = in_rd; m_data = in_result; m_flag = (in_rd != 0);
            end else begin
              waiting = 1'b1; p_rd = in_rd; p_f3 = in_funct3;
            end
          end
        end else if (mem_done) begin
          waiting = 1'b0; m_cnt++; m_rd = p_rd; m_data = ext_ref(p_f3, mem_rdata); m_flag = (p_rd != 0);
        end
      end
      cyc();
      total++; if (wb_flag !== m_flag) begin bad++; $display("FAIL rnd%0d_flag got=%0h exp=%0h", n, wb_flag, m_flag); end
      total++; if (wb_rd !== m_rd) begin bad++; $display("FAIL rnd%0d_rd got=%0h exp=%0h", n, wb_rd, m_rd); end
      total++; if (wb_data !== m_data) begin bad++; $display("FAIL rnd%0d_data got=%0h exp=%0h", n, wb_data, m_data); end
      total++; if (retire_cnt !== m_cnt) begin bad++; $display("FAIL rnd%0d_cnt got=%0h exp=%0h", n, retire_cnt, m_cnt); end
      total++; if (busy !== waiting) begin bad++; $display("FAIL rnd%0d_busy got=%0h exp=%0h", n, busy, waiting); end
    end
    idle_inputs();
    rdy_in = 1'b1;
  endtask

  initial begin
    exp_cnt = 64'd0;
    test_reset();
    test_alu();
    test_load_ext();
    test_x0_nowb();
    test_freeze();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
